// File: rtl/deser_channel_arbiter_pkg.sv
// Shared definitions for the deserializer channel arbiter: word length and arbiter states.
package deser_channel_arbiter_pkg;

  localparam int unsigned FIR_WORD_LEN = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ABORT = 2'd3
  } arb_state_e;

endpackage

// File: rtl/deser_channel_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module deser_channel_arbiter_rr_picker
  import deser_channel_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         i_req,
  input  logic [$clog2(NUM_CH)-1:0] i_ptr,
  output logic [NUM_CH-1:0]         o_grant,
  output logic [$clog2(NUM_CH)-1:0] o_idx,
  output logic                      o_any
);

  localparam int unsigned TAG_W = $clog2(NUM_CH);

  logic             found;
  logic [TAG_W-1:0] cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = TAG_W'((32'(i_ptr) + i) % NUM_CH);
      if (!found && i_req[cand]) begin
        found         = 1'b1;
        o_grant[cand] = 1'b1;
        o_idx         = cand;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/deser_channel_arbiter.sv
// Shares one serial deserializer between NUM_CH sources: round-robin per word,
// holds grant until the FIR consumes the word, aborts stalled streams.
module deser_channel_arbiter
  import deser_channel_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned LENGTH  = FIR_WORD_LEN,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic [NUM_CH-1:0]         iv_req,
  input  logic [NUM_CH-1:0]         iv_din,
  input  logic [NUM_CH-1:0]         iv_din_valid,
  output logic [NUM_CH-1:0]         ov_ready,
  output logic                      o_des_din,
  output logic                      o_des_din_valid,
  input  logic                      i_des_ready,
  input  logic                      i_des_dout_valid,
  input  logic                      i_fir_ready,
  output logic                      o_des_rst,
  output logic [NUM_CH-1:0]         ov_grant,
  output logic [$clog2(NUM_CH)-1:0] ov_tag,
  output logic                      o_word_done,
  output logic                      o_abort,
  output logic                      o_busy
);

  localparam int unsigned TAG_W = $clog2(NUM_CH);
  localparam int unsigned BIT_W = $clog2(LENGTH + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  arb_state_e        st_q, st_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [TAG_W-1:0]  ptr_q, ptr_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  logic [NUM_CH-1:0] pick_grant;
  logic [TAG_W-1:0]  pick_idx;
  logic              pick_any;
  logic              streaming;
  logic              beat;
  logic [BIT_W-1:0]  bit_inc;
  logic [TMO_W-1:0]  tmo_inc;
  logic [TAG_W-1:0]  tag_nxt;

  deser_channel_arbiter_rr_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .i_req   (iv_req),
    .i_ptr   (ptr_q),
    .o_grant (pick_grant),
    .o_idx   (pick_idx),
    .o_any   (pick_any)
  );

  // Data mux follows the registered grant; bits only flow while streaming and enabled.
  assign streaming       = i_en & (st_q == ST_GRANT);
  assign o_des_din       = iv_din[tag_q];
  assign o_des_din_valid = iv_din_valid[tag_q] & streaming;
  assign ov_ready        = grant_q & {NUM_CH{i_des_ready & streaming}};
  assign beat            = o_des_din_valid & i_des_ready;

  assign bit_inc = (bit_cnt_q == BIT_W'(LENGTH))  ? bit_cnt_q : bit_cnt_q + BIT_W'(1);
  assign tmo_inc = (tmo_cnt_q == TMO_W'(TIMEOUT)) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
  assign tag_nxt = (tag_q == TAG_W'(NUM_CH - 1))  ? '0 : tag_q + TAG_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q      <= ST_IDLE;
      grant_q   <= '0;
      tag_q     <= '0;
      ptr_q     <= '0;
      bit_cnt_q <= '0;
      tmo_cnt_q <= '0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      st_q      <= st_d;
      grant_q   <= grant_d;
      tag_q     <= tag_d;
      ptr_q     <= ptr_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    grant_d   = grant_q;
    tag_d     = tag_q;
    ptr_d     = ptr_q;
    bit_cnt_d = bit_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    if (i_en) begin
      case (st_q)
        ST_IDLE: begin
          if (pick_any) begin
            st_d      = ST_GRANT;
            grant_d   = pick_grant;
            tag_d     = pick_idx;
            bit_cnt_d = '0;
            tmo_cnt_d = '0;
          end
        end
        ST_GRANT: begin
          // A beat clears the idle count, so it wins over a same-cycle timeout.
          if (beat) begin
            bit_cnt_d = bit_inc;
            tmo_cnt_d = '0;
            if (bit_inc == BIT_W'(LENGTH)) st_d = ST_DRAIN;
          end else begin
            tmo_cnt_d = tmo_inc;
            if (tmo_inc == TMO_W'(TIMEOUT)) begin
              st_d    = ST_ABORT;
              abort_d = 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (i_des_dout_valid & i_fir_ready) begin
            st_d      = ST_IDLE;
            done_d    = 1'b1;
            ptr_d     = tag_nxt;
            grant_d   = '0;
            bit_cnt_d = '0;
          end
        end
        ST_ABORT: begin
          st_d      = ST_IDLE;
          ptr_d     = tag_nxt;
          grant_d   = '0;
          bit_cnt_d = '0;
          tmo_cnt_d = '0;
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  assign ov_grant    = grant_q;
  assign ov_tag      = tag_q;
  assign o_word_done = done_q;
  assign o_abort     = abort_q;
  assign o_des_rst   = abort_q;
  assign o_busy      = (st_q != ST_IDLE);

endmodule
